// File: rtl/tgate_bus_reader.sv
// tgate_bus_reader: break-before-make read sequencer for TGATE drivers sharing one net.
// Define TGATE_RD_KEEPER_EN to keep the last successfully read source selected between reads.
module tgate_bus_reader #(
    parameter int NUM_SRC    = 8,
    parameter int DATA_W     = 8,
    parameter int DEAD_CYC   = 2,
    parameter int SETTLE_CYC = 3,
    localparam int SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic              clk,
    input  logic              resetb,
    input  logic              req_valid,
    input  logic [SRC_W-1:0]  req_src,
    output logic              req_ready,
    output logic [NUM_SRC-1:0] sel,
    output logic [NUM_SRC-1:0] selb,
    input  logic [DATA_W-1:0] bus_in,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_err
);
    localparam int MAX_CYC = (DEAD_CYC > SETTLE_CYC) ? DEAD_CYC : SETTLE_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
`ifdef TGATE_RD_KEEPER_EN
    localparam bit KEEP = 1'b1;
`else
    localparam bit KEEP = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, BREAK, DRIVE, HOLD} state_t;

    state_t            state_q, state_d;
    logic [SRC_W-1:0]  src_q, src_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_err_q, rd_err_d;
    logic              keep_vld_q, keep_vld_d;
    logic [SRC_W-1:0]  keep_idx_q, keep_idx_d;
    logic              err_req;
    logic              sel_on;
    logic [SRC_W-1:0]  sel_idx;

    assign err_req = 32'(req_src) >= NUM_SRC;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        cnt_d      = cnt_q;
        rd_data_d  = rd_data_q;
        rd_err_d   = rd_err_q;
        keep_vld_d = keep_vld_q;
        keep_idx_d = keep_idx_q;
        case (state_q)
            IDLE: if (req_valid) begin
                src_d     = req_src;
                rd_data_d = '0;
                rd_err_d  = err_req;
                cnt_d     = '0;
                if (err_req) begin
                    state_d = HOLD;
                end else if (KEEP && keep_vld_q && keep_idx_q == req_src) begin
                    // Same source already driving the net: no break needed.
                    state_d = DRIVE;
                    cnt_d   = CNT_W'(SETTLE_CYC - 1);
                end else begin
                    state_d = BREAK;
                    cnt_d   = CNT_W'(DEAD_CYC - 1);
                end
            end
            BREAK: if (cnt_q == '0) begin
                state_d = DRIVE;
                cnt_d   = CNT_W'(SETTLE_CYC - 1);
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            DRIVE: if (cnt_q == '0) begin
                state_d    = HOLD;
                rd_data_d  = bus_in;
                keep_vld_d = 1'b1;
                keep_idx_d = src_q;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
            HOLD: if (rd_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= IDLE;
            src_q      <= '0;
            cnt_q      <= '0;
            rd_data_q  <= '0;
            rd_err_q   <= 1'b0;
            keep_vld_q <= 1'b0;
            keep_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            cnt_q      <= cnt_d;
            rd_data_q  <= rd_data_d;
            rd_err_q   <= rd_err_d;
            keep_vld_q <= keep_vld_d;
            keep_idx_q <= keep_idx_d;
        end
    end

    // Selects decode straight from flopped state so reset drops them without a clock.
    always_comb begin
        sel_idx = (state_q == DRIVE) ? src_q : keep_idx_q;
        sel_on  = (state_q == DRIVE) ||
                  (KEEP && keep_vld_q && (state_q == IDLE || state_q == HOLD));
        sel     = '0;
        for (int i = 0; i < NUM_SRC; i++) sel[i] = sel_on && (sel_idx == SRC_W'(i));
    end

    assign selb      = ~sel;
    assign req_ready = state_q == IDLE;
    assign rd_valid  = state_q == HOLD;
    assign rd_data   = rd_data_q;
    assign rd_err    = rd_err_q;

`ifndef SYNTHESIS
    a_sel_onehot0: assert property (@(posedge clk) disable iff (!resetb) $onehot0(sel));
    a_selb_comp: assert property (@(posedge clk) disable iff (!resetb) selb == ~sel);
`endif
endmodule

// File: tb/tb_tgate_bus_reader.sv
// tb_tgate_bus_reader: randomized reads checked against a cycle-schedule model of the reader.
module tb_tgate_bus_reader;
    localparam int NS = 6;
    localparam int DW = 8;
    localparam int DC = 2;
    localparam int SC = 3;
    localparam int SW = 3;
`ifdef TGATE_RD_KEEPER_EN
    localparam bit KEEP = 1'b1;
`else
    localparam bit KEEP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          resetb = 1'b0;
    logic          req_valid = 1'b0;
    logic [SW-1:0] req_src = '0;
    logic          req_ready;
    logic [NS-1:0] sel, selb;
    logic [DW-1:0] bus_in = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [DW-1:0] rd_data;
    logic          rd_err;

    int n_chk = 0;
    int n_pass = 0;
    bit kv = 1'b0;
    int ki = 0;

    always #5 clk = ~clk;

    tgate_bus_reader #(.NUM_SRC(NS), .DATA_W(DW), .DEAD_CYC(DC), .SETTLE_CYC(SC)) dut (
        .clk(clk), .resetb(resetb), .req_valid(req_valid), .req_src(req_src),
        .req_ready(req_ready), .sel(sel), .selb(selb), .bus_in(bus_in),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_err(rd_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic [NS-1:0] oh(input int s);
        logic [NS-1:0] one = 1;
        return (s >= 0 && s < NS) ? (one << s) : '0;
    endfunction

    function automatic logic [NS-1:0] idle_sel();
        return (KEEP && kv) ? oh(ki) : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every cycle: one-hot-or-zero select, complementary selb, and a dead gap on every source change.
    initial begin
        bit            seen = 1'b0;
        logic [NS-1:0] last = '0;
        int            zrun = 0;
        forever begin
            @(negedge clk);
            if (!resetb) begin
                seen = 1'b0;
                zrun = 0;
            end else begin
                chk("onehot0", 32'($onehot0(sel)), 1);
                chk("selb", selb, NS'(~sel));
                if (sel != '0) begin
                    if (seen && sel != last) chk("gap", 32'(zrun >= DC), 1);
                    last = sel;
                    seen = 1'b1;
                    zrun = 0;
                end else begin
                    zrun++;
                end
            end
        end
    end

    task automatic do_read(input int src, input logic [DW-1:0] d, input int wait_n, input bit overlap);
        bit err = src >= NS;
        bit same = KEEP && kv && ki == src && !err;
        logic [DW-1:0] exp_d = err ? '0 : d;
        chk("req_ready_idle", req_ready, 1);
        chk("sel_idle", sel, idle_sel());
        req_valid = 1'b1;
        req_src = SW'(src);
        bus_in = d;
        tick();
        req_valid = 1'b0;
        if (!err) begin
            for (int i = 0; i < (same ? 0 : DC); i++) begin
                chk("sel_break", sel, 0);
                chk("req_ready_busy", req_ready, 0);
                chk("rd_valid_busy", rd_valid, 0);
                tick();
            end
            for (int i = 0; i < SC; i++) begin
                chk("sel_drive", sel, oh(src));
                chk("rd_valid_busy", rd_valid, 0);
                tick();
            end
            kv = 1'b1;
            ki = src;
        end
        chk("rd_valid", rd_valid, 1);
        chk("rd_err", rd_err, 32'(err));
        chk("rd_data", rd_data, exp_d);
        chk("sel_hold", sel, idle_sel());
        for (int i = 0; i < wait_n; i++) begin
            bus_in = DW'($urandom);
            tick();
            chk("rd_valid_wait", rd_valid, 1);
            chk("rd_data_stable", rd_data, exp_d);
            chk("req_ready_hold", req_ready, 0);
            chk("sel_hold", sel, idle_sel());
        end
        rd_ready = 1'b1;
        if (overlap) begin
            req_valid = 1'b1;
            req_src = SW'($urandom_range(0, NS - 1));
        end
        tick();
        rd_ready = 1'b0;
        req_valid = 1'b0;
        chk("rd_valid_done", rd_valid, 0);
        chk("req_ready_after", req_ready, 1);
        chk("sel_idle", sel, idle_sel());
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_sel"}, sel, 0);
        chk({tag, "_selb"}, selb, NS'('1));
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rd_valid"}, rd_valid, 0);
        chk({tag, "_rd_data"}, rd_data, 0);
        chk({tag, "_rd_err"}, rd_err, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: run did not complete");
        $fatal(1);
    end

    initial begin
        #2;
        reset_checks("rst");
        @(negedge clk);
        resetb = 1'b1;
        tick();
        do_read(3, 8'hA5, 4, 1'b0);
        do_read(5, 8'h3C, 0, 1'b1);
        do_read(7, 8'h77, 2, 1'b0);
        do_read(2, 8'h12, 0, 1'b0);
        do_read(2, 8'h34, 1, 1'b0);
        do_read(5, 8'h56, 0, 1'b0);
        // Interrupt a read in the middle of its drive window.
        req_valid = 1'b1;
        req_src = SW'(1);
        bus_in = 8'h99;
        tick();
        req_valid = 1'b0;
        repeat (DC + 1) tick();
        chk("sel_pre_reset", sel, oh(1));
        resetb = 1'b0;
        #1;
        reset_checks("mid_rst");
        kv = 1'b0;
        tick();
        tick();
        @(negedge clk);
        resetb = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("post_rst_rd_valid", rd_valid, 0);
            chk("post_rst_req_ready", req_ready, 1);
            chk("post_rst_sel", sel, 0);
        end
        for (int t = 0; t < 40; t++) begin
            int gap = $urandom_range(0, 2);
            do_read($urandom_range(0, 7), DW'($urandom), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("gap_req_ready", req_ready, 1);
                chk("gap_sel", sel, idle_sel());
            end
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
